apb_slave_mem: RTL and testbench



---
 rtl/apb_slv_pkg.sv | 14 +
 rtl/apb_slv_regfile.sv | 24 ++
 rtl/apb_slave_mem.sv | 123 ++++++++++++
 tb/tb_apb_slave_mem.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared state encoding, default sizes and error decode for the APB completer.
package apb_slv_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_WAIT_CYCLES = 0;
  localparam int DEF_CNT_WIDTH = 4;
  localparam logic [DEF_ADDR_WIDTH-1:0] WAIT_CFG_ADDR = '1;
  function automatic logic is_err(input logic [31:0] addr, input logic wr, input logic rd,
                                  input int unsigned depth);
    return (addr >= depth) || (wr == rd);
  endfunction
endpackage

// File: rtl/apb_slv_regfile.sv
// apb_slv_regfile: DEPTH x DATA_WIDTH storage, sync write, comb read, sync clear on prstn=0.
module apb_slv_regfile #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  we,
  input  logic [IW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with wait states, pslverr and a byte register file.
// Optional APB_SLV_WAIT_CFG_EN maps the top address to a writable wait-count register.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic                  pread,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] CFG_ADDR = '1;
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, wait_val;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, prdata_q, prdata_d, mem_rdata, cfg_rdata, rsp_data;
  logic wr_q, wr_d, rd_q, rd_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic sel_wr, sel_rd, is_cfg, err, setup, complete, mem_we;
  // In IDLE the response is decoded from the bus being latched; afterwards from the latched copy.
  assign sel_addr = state_q == IDLE ? paddr : addr_q;
  assign sel_wr = state_q == IDLE ? pwrite : wr_q;
  assign sel_rd = state_q == IDLE ? pread : rd_q;
  assign setup = state_q == IDLE && psel && !penable;
  assign complete = state_q == ACCESS && pready_q;
`ifdef APB_SLV_WAIT_CFG_EN
  logic [3:0] wcfg_q, wcfg_d;
  assign is_cfg = sel_addr == CFG_ADDR;
  assign wait_val = CNT_WIDTH'(wcfg_q);
  assign cfg_rdata = DATA_WIDTH'(wcfg_q);
  assign wcfg_d = complete && wr_q && !err && is_cfg ? wdata_q[3:0] : wcfg_q;
  always_ff @(posedge pclk) wcfg_q <= !prstn ? 4'(WAIT_CYCLES) : wcfg_d;
`else
  assign is_cfg = 1'b0;
  assign wait_val = CNT_WIDTH'(WAIT_CYCLES);
  assign cfg_rdata = '0;
`endif
  assign err = is_cfg ? sel_wr == sel_rd : is_err(32'(sel_addr), sel_wr, sel_rd, unsigned'(DEPTH));
  assign rsp_data = !sel_rd || sel_wr || err ? '0 : is_cfg ? cfg_rdata : mem_rdata;
  assign mem_we = complete && wr_q && !err && !is_cfg;
  apb_slv_regfile #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .pclk  (pclk),
    .prstn (prstn),
    .we    (mem_we),
    .waddr (addr_q[IW-1:0]),
    .wdata (wdata_q),
    .raddr (sel_addr[IW-1:0]),
    .rdata (mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    rd_d = rd_q;
    pready_d = pready_q;
    pslverr_d = pslverr_q;
    prdata_d = prdata_q;
    if (setup) begin
      state_d = ACCESS;
      cnt_d = wait_val;
      addr_d = paddr;
      wdata_d = pwdata;
      wr_d = pwrite;
      rd_d = pread;
      pready_d = wait_val == '0;
      pslverr_d = wait_val == '0 && err;
      prdata_d = wait_val == '0 ? rsp_data : '0;
    end else if (complete) begin
      state_d = IDLE;
      pready_d = 1'b0;
      pslverr_d = 1'b0;
      prdata_d = '0;
    end else if (state_q == ACCESS && !psel) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == ACCESS && penable) begin
      cnt_d = cnt_q - 1'b1;
      pready_d = cnt_q == CNT_WIDTH'(1);
      pslverr_d = cnt_q == CNT_WIDTH'(1) && err;
      prdata_d = cnt_q == CNT_WIDTH'(1) ? rsp_data : '0;
    end
  end
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
    end
  end
  assign pready = pready_q;
  assign pslverr = pslverr_q;
  assign prdata = prdata_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: table-driven APB transfers on three completers (0, 2 and 3 wait states).
module tb_apb_slave_mem;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic prstn, penable, pwrite, pread;
  logic [2:0] psel, pready, pslverr;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata [3];
  apb_slave_mem #(.WAIT_CYCLES(0)) u0 (.pclk(pclk), .prstn(prstn), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pread(pread), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]));
  apb_slave_mem #(.WAIT_CYCLES(2)) u1 (.pclk(pclk), .prstn(prstn), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pread(pread), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]));
  apb_slave_mem #(.WAIT_CYCLES(3)) u2 (.pclk(pclk), .prstn(prstn), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pread(pread), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]));
  typedef struct {
    int d; logic wr; logic rd; logic [7:0] addr; logic [7:0] data;
    logic err; logic [7:0] rdata; int waits;
  } vec_t;
  typedef struct {logic err; logic [7:0] rdata; int waits;} exp_t;
  exp_t sb[$];
  vec_t tbl[14];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  // Called at a negedge; drives setup, waits for pready, ends one negedge after completion.
  task automatic xfer(input int d, input logic wr, input logic rd, input logic [7:0] addr,
                      input logic [7:0] data, input logic eerr, input logic [7:0] erdata,
                      input int ewaits, input string tag);
    exp_t e;
    int w = 0;
    logic done = 1'b0;
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    pread = rd;
    paddr = addr;
    pwdata = data;
    sb.push_back('{eerr, erdata, ewaits});
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      penable = 1'b1;
      if (pready[d]) begin
        e = sb.pop_front();
        chk({tag, " waits"}, w, e.waits);
        chk({tag, " pslverr"}, pslverr[d], e.err);
        if (rd && !wr) chk({tag, " prdata"}, prdata[d], e.rdata);
        done = 1'b1;
      end else w++;
    end
    chk({tag, " done"}, done, 1);
    if (!done) e = sb.pop_front();
    @(negedge pclk);
    chk({tag, " pready drop"}, pready[d], 0);
    psel = '0;
    penable = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{0, 1, 0, 8'h05, 8'h3C, 0, 8'h00, 0};
    tbl[1]  = '{0, 0, 1, 8'h05, 8'h00, 0, 8'h3C, 0};
    tbl[2]  = '{0, 1, 0, 8'h20, 8'hAA, 1, 8'h00, 0};
    tbl[3]  = '{0, 0, 1, 8'h20, 8'h00, 1, 8'h00, 0};
    tbl[4]  = '{0, 1, 1, 8'h03, 8'h77, 1, 8'h00, 0};
    tbl[5]  = '{0, 0, 0, 8'h03, 8'h77, 1, 8'h00, 0};
    tbl[6]  = '{0, 0, 1, 8'h03, 8'h00, 0, 8'h00, 0};
    tbl[7]  = '{0, 0, 1, 8'h0F, 8'h00, 0, 8'h00, 0};
    tbl[8]  = '{0, 0, 1, 8'h10, 8'h00, 1, 8'h00, 0};
    tbl[9]  = '{1, 1, 0, 8'h05, 8'h3C, 0, 8'h00, 2};
    tbl[10] = '{1, 0, 1, 8'h05, 8'h00, 0, 8'h3C, 2};
    tbl[11] = '{1, 0, 1, 8'h05, 8'h00, 0, 8'h3C, 2};
    tbl[12] = '{2, 1, 0, 8'h06, 8'h5A, 0, 8'h00, 3};
    tbl[13] = '{2, 0, 1, 8'h06, 8'h00, 0, 8'h5A, 3};
    prstn = 1'b0;
    psel = '0;
    penable = 1'b0;
    pwrite = 1'b0;
    pread = 1'b0;
    paddr = '0;
    pwdata = '0;
    repeat (2) @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset pready%0d", i), pready[i], 0);
      chk($sformatf("reset pslverr%0d", i), pslverr[i], 0);
      chk($sformatf("reset prdata%0d", i), prdata[i], 0);
    end
    prstn = 1'b1;
    @(negedge pclk);
    for (int i = 0; i < 14; i++)
      xfer(tbl[i].d, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].err, tbl[i].rdata,
           tbl[i].waits, $sformatf("vec%0d", i));
    for (int a = 0; a < 16; a++)
      xfer(0, 0, 1, 8'(a), 8'h00, 0, a == 5 ? 8'h3C : 8'h00, 0, $sformatf("sweep%0d", a));
`ifdef APB_SLV_WAIT_CFG_EN
    xfer(0, 1, 0, 8'hFF, 8'h03, 0, 8'h00, 0, "cfg wr");
    xfer(0, 0, 1, 8'h05, 8'h00, 0, 8'h3C, 3, "cfg rd05");
    xfer(0, 0, 1, 8'hFF, 8'h00, 0, 8'h03, 3, "cfg rdFF");
`else
    xfer(0, 0, 1, 8'hFF, 8'h00, 1, 8'h00, 0, "rdFF");
`endif
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    pread = 1'b0;
    paddr = 8'h08;
    pwdata = 8'h99;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    chk("abort wait", pready[2], 0);
    psel = '0;
    penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk($sformatf("abort pready%0d", i), pready[2], 0);
      chk($sformatf("abort pslverr%0d", i), pslverr[2], 0);
    end
    xfer(2, 0, 1, 8'h08, 8'h00, 0, 8'h00, 3, "abort rd08");
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    pread = 1'b0;
    paddr = 8'h07;
    pwdata = 8'h55;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    prstn = 1'b0;
    @(negedge pclk);
    chk("rst pready", pready[2], 0);
    prstn = 1'b1;
    psel = '0;
    penable = 1'b0;
    @(negedge pclk);
    xfer(2, 0, 1, 8'h07, 8'h00, 0, 8'h00, 3, "rst rd07");
    xfer(0, 0, 1, 8'h05, 8'h00, 0, 8'h00, 0, "rst rd05");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
